// File: rtl/i2d_core_defines.sv
// rtl/i2d_core_defines.sv - shared i2d core types: instruction layout, opcodes, EX state, helpers
// Contents: opcode_t, instr_t, ex_state_t, FLUSH_NOP_TAG / FLUSH_NOP_INSTR, is_alu_op().
package i2d_core_defines;

    typedef enum logic [5:0] {
        OPCODE_NOP  = 6'd0,
        OPCODE_ADD,
        OPCODE_ADDC,
        OPCODE_SUB,
        OPCODE_SUBC,
        OPCODE_MUL,
        OPCODE_DIV,
        OPCODE_AND,
        OPCODE_OR,
        OPCODE_NOT,
        OPCODE_LSL,
        OPCODE_LSR,
        OPCODE_ASL,
        OPCODE_ASR,
        OPCODE_MOV,
        OPCODE_LD,
        OPCODE_ST,
        OPCODE_JMP
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  regd_cond;
        logic [4:0]  rega;
        logic [4:0]  regb;
        logic [10:0] imm;
    } instr_t;

    typedef enum logic {
        RUN    = 1'b0,
        LDWAIT = 1'b1
    } ex_state_t;

    // Payload of the NOP inserted by a flush; distinguishes it from a reset/bubble NOP.
    localparam logic [25:0] FLUSH_NOP_TAG   = 26'(1);
    localparam logic [31:0] FLUSH_NOP_INSTR = {6'(OPCODE_NOP), FLUSH_NOP_TAG};

    function automatic logic is_alu_op(input opcode_t op);
        case (op)
            OPCODE_ADD, OPCODE_ADDC, OPCODE_SUB, OPCODE_SUBC, OPCODE_MUL,
            OPCODE_DIV, OPCODE_AND, OPCODE_OR, OPCODE_NOT, OPCODE_LSL,
            OPCODE_LSR, OPCODE_ASL, OPCODE_ASR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_ex_ldwait.sv
// rtl/core_ex_ldwait.sv - load-wait FSM with timeout counter and one-entry response buffer
// Ports: clk, rst (async, active-high); start (LD captured), halt, abort (unhalted flush);
//        mau_valid/mau_data (load response); busy (in LDWAIT), mau_req, ld_done/ld_data
//        (writeback this cycle), ld_timeout (one-cycle abort pulse).
module core_ex_ldwait
    import i2d_core_defines::*;
#(
    parameter int XLEN         = 32,
    parameter int MAU_MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic            abort,
    input  logic            mau_valid,
    input  logic [XLEN-1:0] mau_data,
    output logic            busy,
    output logic            mau_req,
    output logic            ld_done,
    output logic [XLEN-1:0] ld_data,
    output logic            ld_timeout
);

    localparam int CW = $clog2(MAU_MAX_WAIT);

    ex_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            buf_full_q, buf_full_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;

    assign busy    = (state_q == LDWAIT);
    assign mau_req = (state_q == LDWAIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        ld_done    = 1'b0;
        ld_data    = '0;
        ld_timeout = 1'b0;

        if (state_q == LDWAIT) begin
            if (halt) begin
                // Response arriving while frozen is parked; counter holds.
                if (mau_valid && !buf_full_q) begin
                    buf_full_d = 1'b1;
                    buf_data_d = mau_data;
                end
            end else if (abort) begin
                state_d    = RUN;
                buf_full_d = 1'b0;
            end else if (buf_full_q) begin
                ld_done    = 1'b1;
                ld_data    = buf_data_q;
                buf_full_d = 1'b0;
                state_d    = RUN;
            end else if (mau_valid) begin
                ld_done = 1'b1;
                ld_data = mau_data;
                state_d = RUN;
            end else if (cnt_q == CW'(MAU_MAX_WAIT - 1)) begin
                ld_timeout = 1'b1;
                state_d    = RUN;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A new LD may be captured in the same cycle the previous one completes.
        if (start) begin
            state_d    = LDWAIT;
            cnt_d      = '0;
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
        end
    end

endmodule

// File: rtl/core_ex_wb.sv
// rtl/core_ex_wb.sv - i2d execute/writeback stage: occupant register, writeback select, load wait
// Ports: clk, rst (async, active-high); id_valid/id_ready/id_instr/id_pc from ID; ex_halt, flush;
//        alu_result, rega_data; mau_req/mau_valid/mau_data load interface; ex_instr/ex_pc/ex_valid
//        occupant; wb/wb_addr/wb_data register-file write; ld_timeout pulse.
// Option CORE_EX_FWD_EN: adds fwd_valid/fwd_addr/fwd_data, a registered copy of the writeback.
module core_ex_wb
    import i2d_core_defines::*;
#(
    parameter int XLEN         = 32,
    parameter int RAW          = 4,
    parameter int MAU_MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  instr_t          id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic            ex_halt,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rega_data,
    output logic            mau_req,
    input  logic            mau_valid,
    input  logic [XLEN-1:0] mau_data,
    output instr_t          ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_valid,
    output logic            wb,
    output logic [RAW-1:0]  wb_addr,
    output logic [XLEN-1:0] wb_data,
`ifdef CORE_EX_FWD_EN
    output logic            fwd_valid,
    output logic [RAW-1:0]  fwd_addr,
    output logic [XLEN-1:0] fwd_data,
`endif
    output logic            ld_timeout
);

    instr_t          instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            flush_pend_q, flush_pend_d;

    logic            flush_eff;
    logic            capture;
    logic            start_ld;
    logic            ld_busy;
    logic            ld_done;
    logic [XLEN-1:0] ld_data;

    // A flush requested during halt takes effect in the first unhalted cycle.
    assign flush_eff = !ex_halt && (flush || flush_pend_q);
    assign id_ready  = !ex_halt && (!ld_busy || ld_done);
    // Flush overrides capture: the ID-side instruction is squashed along with the occupant.
    assign capture   = id_ready && !flush_eff;
    assign start_ld  = capture && id_valid && (id_instr.opcode == OPCODE_LD);

    core_ex_ldwait #(
        .XLEN         (XLEN),
        .MAU_MAX_WAIT (MAU_MAX_WAIT)
    ) u_ldwait (
        .clk        (clk),
        .rst        (rst),
        .start      (start_ld),
        .halt       (ex_halt),
        .abort      (flush_eff),
        .mau_valid  (mau_valid),
        .mau_data   (mau_data),
        .busy       (ld_busy),
        .mau_req    (mau_req),
        .ld_done    (ld_done),
        .ld_data    (ld_data),
        .ld_timeout (ld_timeout)
    );

    // In RUN the occupant is replaced every unhalted cycle, so its first unhalted
    // cycle is also its last: writeback here fires exactly once.
    always_comb begin
        wb      = 1'b0;
        wb_data = '0;
        if (!ex_halt && !flush_eff) begin
            if (ld_done) begin
                wb      = 1'b1;
                wb_data = ld_data;
            end else if (!ld_busy && valid_q) begin
                if (is_alu_op(instr_q.opcode)) begin
                    wb      = 1'b1;
                    wb_data = alu_result;
                end else if (instr_q.opcode == OPCODE_MOV) begin
                    wb      = 1'b1;
                    wb_data = rega_data;
                end
            end
        end
        wb_addr = wb ? instr_q.regd_cond[RAW-1:0] : '0;
    end

    always_comb begin
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        if (ex_halt) begin
            if (flush) flush_pend_d = 1'b1;
        end else if (flush_eff) begin
            instr_d      = instr_t'(FLUSH_NOP_INSTR);
            valid_d      = 1'b0;
            flush_pend_d = 1'b0;
        end else if (capture) begin
            if (id_valid) begin
                instr_d = id_instr;
                pc_d    = id_pc;
                valid_d = 1'b1;
            end else begin
                instr_d = '0;
                pc_d    = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q      <= '0;
            pc_q         <= '0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign ex_instr = instr_q;
    assign ex_pc    = pc_q;
    assign ex_valid = valid_q;

`ifdef CORE_EX_FWD_EN
    logic            fwd_valid_q, fwd_valid_d;
    logic [RAW-1:0]  fwd_addr_q, fwd_addr_d;
    logic [XLEN-1:0] fwd_data_q, fwd_data_d;

    always_comb begin
        fwd_valid_d = wb;
        fwd_addr_d  = wb_addr;
        fwd_data_d  = wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_addr  = fwd_addr_q;
    assign fwd_data  = fwd_data_q;
`endif

endmodule

// File: tb/tb_core_ex_wb.sv
// tb/tb_core_ex_wb.sv - scoreboard bench for core_ex_wb with randomized instruction stream
module tb_core_ex_wb;
    import i2d_core_defines::*;

    localparam int XLEN = 32;
    localparam int RAW  = 4;
    localparam int MAXW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic            id_ready;
    instr_t          id_instr = '0;
    logic [XLEN-1:0] id_pc = '0;
    logic            ex_halt = 1'b0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] alu_result = '0;
    logic [XLEN-1:0] rega_data = '0;
    logic            mau_req;
    logic            mau_valid = 1'b0;
    logic [XLEN-1:0] mau_data = '0;
    instr_t          ex_instr;
    logic [XLEN-1:0] ex_pc;
    logic            ex_valid;
    logic            wb;
    logic [RAW-1:0]  wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ld_timeout;
`ifdef CORE_EX_FWD_EN
    logic            fwd_valid;
    logic [RAW-1:0]  fwd_addr;
    logic [XLEN-1:0] fwd_data;
`endif

    core_ex_wb #(.XLEN(XLEN), .RAW(RAW), .MAU_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .ex_halt(ex_halt), .flush(flush),
        .alu_result(alu_result), .rega_data(rega_data), .mau_req(mau_req),
        .mau_valid(mau_valid), .mau_data(mau_data), .ex_instr(ex_instr),
        .ex_pc(ex_pc), .ex_valid(ex_valid), .wb(wb), .wb_addr(wb_addr),
        .wb_data(wb_data),
`ifdef CORE_EX_FWD_EN
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
        .ld_timeout(ld_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RAW-1:0]  addr;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    function automatic logic writes_alu(input opcode_t op);
        return op inside {OPCODE_ADD, OPCODE_ADDC, OPCODE_SUB, OPCODE_SUBC, OPCODE_MUL,
                          OPCODE_DIV, OPCODE_AND, OPCODE_OR, OPCODE_NOT, OPCODE_LSL,
                          OPCODE_LSR, OPCODE_ASL, OPCODE_ASR};
    endfunction

    // Monitor: every register-file write must match the oldest outstanding expectation.
    logic            prev_wb = 1'b0;
    logic [RAW-1:0]  prev_addr = '0;
    logic [XLEN-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_wb = 1'b0;
        end else begin
            if (wb !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 64'(wb), 64'(0));
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    check("wb_addr", 64'(wb_addr), 64'(e.addr));
                    check("wb_data", 64'(wb_data), 64'(e.data));
                end
            end
`ifdef CORE_EX_FWD_EN
            check("fwd_valid", 64'(fwd_valid), 64'(prev_wb));
            if (prev_wb) begin
                check("fwd_addr", 64'(fwd_addr), 64'(prev_addr));
                check("fwd_data", 64'(fwd_data), 64'(prev_data));
            end
`endif
            prev_wb   = (wb === 1'b1);
            prev_addr = wb_addr;
            prev_data = wb_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and return once it has been captured (at posedge+1).
    task automatic accept(input opcode_t op, input logic [4:0] rd, output int tries);
        instr_t ins;
        logic   rdy;
        ins           = instr_t'($urandom);
        ins.opcode    = op;
        ins.regd_cond = rd;
        id_valid = 1'b1;
        id_instr = ins;
        id_pc    = $urandom;
        tries    = 0;
        do begin
            @(negedge clk);
            rdy = id_ready;
            cyc();
            tries++;
        end while (!rdy && tries < 40);
        check("accept", 64'(rdy), 64'(1));
        id_valid = 1'b0;
        id_instr = '0;
    endtask

    task automatic issue(input opcode_t op, input logic [4:0] rd, input logic [XLEN-1:0] val,
                         input int ld_delay, output int tries);
        wb_t e;
        accept(op, rd, tries);
        e.addr = rd[RAW-1:0];
        e.data = val;
        if (writes_alu(op)) begin
            alu_result = val;
            rega_data  = ~val;
            exp_q.push_back(e);
        end else if (op == OPCODE_MOV) begin
            alu_result = ~val;
            rega_data  = val;
            exp_q.push_back(e);
        end else begin
            alu_result = $urandom;
            rega_data  = $urandom;
        end
        if (op == OPCODE_LD) begin
            for (int i = 0; i < ld_delay; i++) begin
                @(negedge clk);
                check("ld_req", 64'(mau_req), 64'(i < MAXW));
                check("ld_ready", 64'(id_ready), 64'(i >= MAXW));
                check("ld_timeout", 64'(ld_timeout), 64'(i == MAXW - 1));
                cyc();
            end
            if (ld_delay < MAXW) exp_q.push_back(e);
            mau_valid = 1'b1;
            mau_data  = val;
            @(negedge clk);
            check("ld_resp_ready", 64'(id_ready), 64'(1));
            check("ld_resp_timeout", 64'(ld_timeout), 64'(0));
            cyc();
            mau_valid = 1'b0;
            @(negedge clk);
            check("ld_req_drop", 64'(mau_req), 64'(0));
            cyc();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2;
        check("rst_ex_instr", 64'(ex_instr), 64'(0));
        check("rst_ex_valid", 64'(ex_valid), 64'(0));
        check("rst_wb", 64'(wb), 64'(0));
        check("rst_mau_req", 64'(mau_req), 64'(0));
        check("rst_ld_timeout", 64'(ld_timeout), 64'(0));
`ifdef CORE_EX_FWD_EN
        check("rst_fwd_valid", 64'(fwd_valid), 64'(0));
`endif
        cyc();
        cyc();
        rst = 1'b0;

        // ADD r3 then MOV r4 back to back
        issue(OPCODE_ADD, 5'd3, 32'h5, 0, t);
        check("b2b_add_ready", 64'(t), 64'(1));
        issue(OPCODE_MOV, 5'd4, 32'hA, 0, t);
        check("b2b_mov_ready", 64'(t), 64'(1));

        // LD r2, response after 3 waiting cycles
        issue(OPCODE_LD, 5'd2, 32'hDEAD, 3, t);

        // LD with response buffered during halt
        accept(OPCODE_LD, 5'd9, t);
        ex_halt = 1'b1;
        @(negedge clk);
        check("halt_ld_ready", 64'(id_ready), 64'(0));
        check("halt_ld_req", 64'(mau_req), 64'(1));
        cyc();
        mau_valid = 1'b1;
        mau_data  = 32'h1234;
        cyc();
        mau_valid = 1'b0;
        cyc();
        exp_q.push_back('{addr: 4'd9, data: 32'h1234});
        ex_halt = 1'b0;
        @(negedge clk);
        check("halt_rel_ready", 64'(id_ready), 64'(1));
        cyc();
        @(negedge clk);
        check("halt_rel_req", 64'(mau_req), 64'(0));
        cyc();

        // Timeouts (exact limit and one beyond, with stray response afterwards)
        issue(OPCODE_LD, 5'd6, 32'hBAD0, MAXW, t);
        issue(OPCODE_LD, 5'd6, 32'hBAD1, MAXW + 1, t);

        // Flush while halted over an ADD
        accept(OPCODE_ADD, 5'd7, t);
        alu_result = 32'h55;
        ex_halt = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fh_valid_held", 64'(ex_valid), 64'(1));
        cyc();
        flush = 1'b0;
        cyc();
        ex_halt = 1'b0;
        cyc();
        @(negedge clk);
        check("fh_instr", 64'(ex_instr), 64'({6'(OPCODE_NOP), 26'd1}));
        check("fh_valid", 64'(ex_valid), 64'(0));
        cyc();

        // Unhalted flush during LDWAIT, then a stray response
        accept(OPCODE_LD, 5'd10, t);
        flush = 1'b1;
        @(negedge clk);
        check("fl_req_cur", 64'(mau_req), 64'(1));
        cyc();
        flush = 1'b0;
        mau_valid = 1'b1;
        mau_data = 32'hF00D;
        @(negedge clk);
        check("fl_req_drop", 64'(mau_req), 64'(0));
        check("fl_valid", 64'(ex_valid), 64'(0));
        cyc();
        mau_valid = 1'b0;

        issue(OPCODE_ADD, 5'd5, 32'h77, 0, t);
        cyc();

        // Reset mid-LDWAIT with buffered data
        accept(OPCODE_LD, 5'd11, t);
        ex_halt = 1'b1;
        cyc();
        mau_valid = 1'b1;
        mau_data = 32'hCAFE;
        cyc();
        mau_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_mid_req", 64'(mau_req), 64'(0));
        check("rst_mid_valid", 64'(ex_valid), 64'(0));
        cyc();
        rst = 1'b0;
        ex_halt = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 64'(id_ready), 64'(1));
        check("rst_mid_req2", 64'(mau_req), 64'(0));
        cyc();

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            opcode_t op;
            op = opcode_t'($urandom_range(0, 17));
            issue(op, 5'($urandom_range(0, 15)), $urandom, $urandom_range(0, MAXW + 1), t);
            repeat ($urandom_range(0, 1)) cyc();
        end

        repeat (3) cyc();
        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
